exe_stage_unit: RTL

Execute stage of the 5-stage ARM-subset pipeline, directly downstream of the decode stage and its ID/EXE register. It selects forwarded operands, generates the second operand (immediate rotate, register shift, or memory offset), runs the ALU with NZCV flag generation, and computes the branch target. It owns the architectural status register and the EXE/MEM pipeline register, which feeds the memory stage.

---
 rtl/exe_stage_unit_if.sv | 49 ++++
 rtl/exe_stage_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/exe_stage_unit_if.sv
// Bundle between the ID/EXE register, the EXE stage and the EXE/MEM consumers.
// The master side drives the decoded instruction and forwarding data; the slave side is the EXE stage.
interface exe_stage_unit_if;
   logic        freeze;
   logic [31:0] pc_in;
   logic [31:0] val_rn_in;
   logic [31:0] val_rm_in;
   logic [23:0] signed_immediate_in;
   logic [11:0] shift_operand_in;
   logic        is_immediate_in;
   logic        status_write_enable_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic        wb_enable_in;
   logic        is_branch_in;
   logic [3:0]  execute_command_in;
   logic [3:0]  dest_reg_in;
   logic [1:0]  sel_src1;
   logic [1:0]  sel_src2;
   logic [31:0] mem_fwd_data;
   logic [31:0] wb_fwd_data;
   logic        branch_taken_out;
   logic [31:0] branch_address_out;
   logic [3:0]  status_reg_out;
   logic [31:0] alu_result_out;
   logic [31:0] val_rm_out;
   logic [3:0]  dest_reg_out;
   logic        wb_enable_out;
   logic        mem_read_out;
   logic        mem_write_out;

   modport master (
      output freeze, pc_in, val_rn_in, val_rm_in, signed_immediate_in, shift_operand_in,
             is_immediate_in, status_write_enable_in, mem_read_in, mem_write_in,
             wb_enable_in, is_branch_in, execute_command_in, dest_reg_in,
             sel_src1, sel_src2, mem_fwd_data, wb_fwd_data,
      input  branch_taken_out, branch_address_out, status_reg_out, alu_result_out,
             val_rm_out, dest_reg_out, wb_enable_out, mem_read_out, mem_write_out
   );

   modport slave (
      input  freeze, pc_in, val_rn_in, val_rm_in, signed_immediate_in, shift_operand_in,
             is_immediate_in, status_write_enable_in, mem_read_in, mem_write_in,
             wb_enable_in, is_branch_in, execute_command_in, dest_reg_in,
             sel_src1, sel_src2, mem_fwd_data, wb_fwd_data,
      output branch_taken_out, branch_address_out, status_reg_out, alu_result_out,
             val_rm_out, dest_reg_out, wb_enable_out, mem_read_out, mem_write_out
   );
endinterface

// File: rtl/exe_stage_unit.sv
// Execute stage: operand forwarding, Val2 shifter, ALU with NZCV, branch target,
// plus the status register and the EXE/MEM pipeline register.
module exe_stage_unit (
   input logic             clk,
   input logic             rst,
   exe_stage_unit_if.slave bus
);

   logic [31:0] op_a;
   logic [31:0] op_rm;
   logic [31:0] val2;
   logic [4:0]  rot_amt;
   logic [4:0]  shift_amt;
   logic [31:0] imm_ext;
   logic [32:0] sum;
   logic [31:0] result;
   logic        alu_c;
   logic        alu_v;
   logic        cmd_valid;
   logic [3:0]  nzcv_new;

   logic [31:0] alu_result_d, alu_result_q;
   logic [31:0] val_rm_d, val_rm_q;
   logic [3:0]  dest_reg_d, dest_reg_q;
   logic        wb_enable_d, wb_enable_q;
   logic        mem_read_d, mem_read_q;
   logic        mem_write_d, mem_write_q;
   logic [3:0]  status_d, status_q;

   // Forwarding muxes; select 11 falls back to the register file value.
   always_comb begin
      case (bus.sel_src1)
         2'b01:   op_a = bus.mem_fwd_data;
         2'b10:   op_a = bus.wb_fwd_data;
         default: op_a = bus.val_rn_in;
      endcase
      case (bus.sel_src2)
         2'b01:   op_rm = bus.mem_fwd_data;
         2'b10:   op_rm = bus.wb_fwd_data;
         default: op_rm = bus.val_rm_in;
      endcase
   end

   // Val2: memory offset beats immediate rotate beats register shift.
   always_comb begin
      rot_amt   = {bus.shift_operand_in[11:8], 1'b0};
      shift_amt = bus.shift_operand_in[11:7];
      imm_ext   = {24'd0, bus.shift_operand_in[7:0]};
      if (bus.mem_read_in || bus.mem_write_in) begin
         val2 = {20'd0, bus.shift_operand_in};
      end else if (bus.is_immediate_in) begin
         val2 = (imm_ext >> rot_amt) | (imm_ext << (6'd32 - {1'b0, rot_amt}));
      end else begin
         case (bus.shift_operand_in[6:5])
            2'b00:   val2 = op_rm << shift_amt;
            2'b01:   val2 = op_rm >> shift_amt;
            2'b10:   val2 = $unsigned($signed(op_rm) >>> shift_amt);
            default: val2 = (op_rm >> shift_amt) | (op_rm << (6'd32 - {1'b0, shift_amt}));
         endcase
      end
   end

   // ALU; subtraction is A + ~Val2 + carry-in so C comes out as NOT borrow.
   always_comb begin
      sum       = 33'd0;
      result    = 32'd0;
      alu_c     = status_q[1];
      alu_v     = status_q[0];
      cmd_valid = 1'b1;
      case (bus.execute_command_in)
         4'b0001: result = val2;
         4'b1001: result = ~val2;
         4'b0010, 4'b0011: begin
            sum    = {1'b0, op_a} + {1'b0, val2}
                   + {32'd0, (bus.execute_command_in[0] & status_q[1])};
            result = sum[31:0];
            alu_c  = sum[32];
            alu_v  = (op_a[31] == val2[31]) && (result[31] != op_a[31]);
         end
         4'b0100, 4'b0101: begin
            sum    = {1'b0, op_a} + {1'b0, ~val2}
                   + {32'd0, (bus.execute_command_in[0] ? status_q[1] : 1'b1)};
            result = sum[31:0];
            alu_c  = sum[32];
            alu_v  = (op_a[31] != val2[31]) && (result[31] != op_a[31]);
         end
         4'b0110: result = op_a & val2;
         4'b0111: result = op_a | val2;
         4'b1000: result = op_a ^ val2;
         default: cmd_valid = 1'b0;
      endcase
      if (cmd_valid) begin
         nzcv_new = {result[31], (result == 32'd0), alu_c, alu_v};
      end else begin
         nzcv_new = status_q;
      end
   end

   // Next-state for status and EXE/MEM register; freeze holds everything.
   always_comb begin
      if (bus.status_write_enable_in && !bus.freeze) begin
         status_d = nzcv_new;
      end else begin
         status_d = status_q;
      end
      if (bus.freeze) begin
         alu_result_d = alu_result_q;
         val_rm_d     = val_rm_q;
         dest_reg_d   = dest_reg_q;
         wb_enable_d  = wb_enable_q;
         mem_read_d   = mem_read_q;
         mem_write_d  = mem_write_q;
      end else begin
         alu_result_d = result;
         val_rm_d     = op_rm;
         dest_reg_d   = bus.dest_reg_in;
         wb_enable_d  = bus.wb_enable_in;
         mem_read_d   = bus.mem_read_in;
         mem_write_d  = bus.mem_write_in;
      end
   end

   // State registers; reset wins over freeze.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q     <= 4'd0;
         alu_result_q <= 32'd0;
         val_rm_q     <= 32'd0;
         dest_reg_q   <= 4'd0;
         wb_enable_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         status_q     <= status_d;
         alu_result_q <= alu_result_d;
         val_rm_q     <= val_rm_d;
         dest_reg_q   <= dest_reg_d;
         wb_enable_q  <= wb_enable_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign bus.branch_taken_out   = bus.is_branch_in;
   assign bus.branch_address_out = bus.pc_in + {{6{bus.signed_immediate_in[23]}},
                                                bus.signed_immediate_in, 2'b00};
   assign bus.status_reg_out     = status_q;
   assign bus.alu_result_out     = alu_result_q;
   assign bus.val_rm_out         = val_rm_q;
   assign bus.dest_reg_out       = dest_reg_q;
   assign bus.wb_enable_out      = wb_enable_q;
   assign bus.mem_read_out       = mem_read_q;
   assign bus.mem_write_out      = mem_write_q;

endmodule
